// File: rtl/vga_defs.sv
// Shared definitions for the VGA memory arbiter and display blocks:
// slot schedule geometry and CPU access state encodings.
package vga_defs;

  localparam int SLOT_BITS = 3;
  localparam logic [SLOT_BITS-1:0] VGA_SLOT = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_RDATA = 2'd2,
    ST_ACK   = 2'd3
  } cpu_state_e;

endpackage

// File: rtl/vga_slot_counter.sv
// Free-running memory schedule counter; wraps every 2**SLOT_BITS cycles and
// flags the slot reserved for the VGA fetch.
module vga_slot_counter
  import vga_defs::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [SLOT_BITS-1:0] slot_o,
  output logic                 vga_slot_o
);

  logic [SLOT_BITS-1:0] slot_q;
  logic [SLOT_BITS-1:0] slot_d;

  // next slot, natural wrap at the top of the range
  always_comb begin
    slot_d = slot_q + SLOT_BITS'(1);
  end

  // slot register, restarts at slot 0 on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o     = slot_q;
  assign vga_slot_o = (slot_q == VGA_SLOT);

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port memory arbiter between the CPU load/store path and the VGA
// pixel fetcher. Slot 0 belongs to VGA whenever it asks for a word; the CPU
// is granted the first other cycle after its request is latched.
//
// state | meaning
// IDLE  | waiting for cpu_req, request fields latched on entry to PEND
// PEND  | waiting for an eligible slot; grant cycle drives mem_*
// RDATA | read data returning, captured into cpu_rdata
// ACK   | cpu_ack high for this one cycle
module vga_mem_arbiter
  import vga_defs::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk_50MHz,
  input  logic                  clear,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]      cpu_wdata,
  output logic                  cpu_ack,
  output logic [WIDTH-1:0]      cpu_rdata,
  input  logic                  vga_fetch_en,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic [WIDTH-1:0]      data_from_mem_vga,
  output logic [2:0]            vga_counter,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  logic [SLOT_BITS-1:0] slot;
  logic                 slot_is_vga;

  vga_slot_counter u_slot_counter (
    .clk_i      (clk_50MHz),
    .rst_i      (clear),
    .slot_o     (slot),
    .vga_slot_o (slot_is_vga)
  );

  cpu_state_e           state_q;
  logic                 we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]     wdata_q;
  logic                 ack_q;
  logic [WIDTH-1:0]     rdata_q;
  logic                 vga_cap_q;
  logic [WIDTH-1:0]     vga_data_q;

  logic vga_fetch;
  logic cpu_elig;
  logic cpu_grant;

  // VGA owns the bus outright in its slot; the CPU takes every other cycle
  assign vga_fetch = slot_is_vga & vga_fetch_en;
  assign cpu_elig  = ~vga_fetch;
  assign cpu_grant = (state_q == ST_PEND) & cpu_elig;

  // CPU access FSM with registered ack and read data
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (cpu_elig) begin
            if (we_q) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          rdata_q <= mem_rdata;
          state_q <= ST_ACK;
          ack_q   <= 1'b1;
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // VGA word capture one cycle after its address slot
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      vga_cap_q  <= 1'b0;
      vga_data_q <= '0;
    end else begin
      vga_cap_q <= vga_fetch;
      if (vga_cap_q) begin
        vga_data_q <= mem_rdata;
      end
    end
  end

  // memory bus mux; bus parks at zero when nobody owns the cycle
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vga_fetch) begin
      mem_addr = vga_addr;
    end else if (cpu_grant) begin
      mem_addr  = addr_q;
      mem_we    = we_q;
      mem_wdata = wdata_q;
    end
  end

  assign cpu_ack           = ack_q;
  assign cpu_rdata         = rdata_q;
  assign data_from_mem_vga = vga_data_q;
  assign vga_counter       = slot;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: directed scenarios followed by a
// randomized soak, all compared each cycle against a timestamp-based model.
module tb_vga_mem_arbiter;

  logic        clk_50MHz;
  logic        clear;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        vga_fetch_en;
  logic [15:0] vga_addr;
  logic [15:0] data_from_mem_vga;
  logic [2:0]  vga_counter;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  vga_mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk_50MHz         (clk_50MHz),
    .clear             (clear),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_ack           (cpu_ack),
    .cpu_rdata         (cpu_rdata),
    .vga_fetch_en      (vga_fetch_en),
    .vga_addr          (vga_addr),
    .data_from_mem_vga (data_from_mem_vga),
    .vga_counter       (vga_counter),
    .mem_addr          (mem_addr),
    .mem_we            (mem_we),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  // environment memory: 1-cycle read latency, driven only by the DUT's pins
  logic [15:0] pre  [logic [15:0]];
  logic [15:0] wmem [logic [15:0]];

  function automatic logic [15:0] env_rd(logic [15:0] a);
    if (wmem.exists(a)) return wmem[a];
    if (pre.exists(a)) return pre[a];
    return a ^ 16'h3C5A;
  endfunction

  always @(posedge clk_50MHz) begin
    mem_rdata <= env_rd(mem_addr);
    if (mem_we) wmem[mem_addr] = mem_wdata;
  end

  // reference model state
  logic [15:0] ref_mem [0:65535];
  int          c;
  logic        m_busy;
  int          m_acc_cyc, m_grant_cyc, m_ack_cyc;
  logic        m_we;
  logic [15:0] m_addr, m_wd, m_rd_val;
  logic [15:0] e_rdata, e_vga;
  int          vga_pend_cyc;
  logic [15:0] vga_pend_val;
  logic        last_ack;
  int          m_reqs;

  // observations of the DUT
  logic [15:0] obs_addr [0:7];
  logic [15:0] obs_vga  [0:7];
  int          we_cnt, we_slot, ack_slot, obs_acks;

  int checks;
  int errors;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, c);
    end
  endtask

  task automatic model_reset();
    c = 0;
    m_busy = 1'b0;
    m_acc_cyc = -1;
    m_grant_cyc = -1;
    m_ack_cyc = -1;
    e_rdata = 16'h0;
    e_vga = 16'h0;
    vga_pend_cyc = -1;
    last_ack = 1'b0;
  endtask

  task automatic preload(logic [15:0] a, logic [15:0] d);
    pre[a] = d;
    ref_mem[a] = d;
  endtask

  // evaluate one cycle: inputs are already applied; returns 1 ns after the next edge
  task automatic tick();
    int          s;
    logic        vs, e_ack, was_busy, grant, chk_wd, e_we;
    logic [15:0] e_addr, e_wd;
    @(negedge clk_50MHz);
    s = c % 8;
    vs = (s == 0) && vga_fetch_en;
    was_busy = m_busy;
    grant = 1'b0;
    chk_wd = 1'b1;
    e_we = 1'b0;
    e_addr = 16'h0;
    e_wd = 16'h0;
    e_ack = m_busy && (m_ack_cyc == c);
    if (e_ack && !m_we) e_rdata = m_rd_val;
    if (vga_pend_cyc >= 0 && c == vga_pend_cyc + 2) e_vga = vga_pend_val;
    if (vs) begin
      e_addr = vga_addr;
      vga_pend_cyc = c;
      vga_pend_val = ref_mem[vga_addr];
    end else if (m_busy && m_grant_cyc < 0 && c > m_acc_cyc) begin
      grant = 1'b1;
      m_grant_cyc = c;
      m_ack_cyc = c + (m_we ? 1 : 2);
      e_addr = m_addr;
      e_we = m_we;
      if (m_we) e_wd = m_wd;
      else begin
        chk_wd = 1'b0;
        m_rd_val = ref_mem[m_addr];
      end
    end
    chk("vga_counter", {29'b0, vga_counter}, 32'(s));
    chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
    chk("mem_addr", {16'b0, mem_addr}, {16'b0, e_addr});
    if (chk_wd) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, e_wd});
    chk("cpu_ack", {31'b0, cpu_ack}, {31'b0, e_ack});
    chk("cpu_rdata", {16'b0, cpu_rdata}, {16'b0, e_rdata});
    chk("vga_data", {16'b0, data_from_mem_vga}, {16'b0, e_vga});
    obs_addr[s] = mem_addr;
    obs_vga[s] = data_from_mem_vga;
    if (mem_we) begin we_cnt++; we_slot = s; end
    if (cpu_ack) begin ack_slot = int'(vga_counter); obs_acks++; end
    if (grant && m_we) ref_mem[m_addr] = m_wd;
    if (e_ack) m_busy = 1'b0;
    if (!was_busy && cpu_req) begin
      m_busy = 1'b1;
      m_reqs++;
      m_acc_cyc = c;
      m_grant_cyc = -1;
      m_ack_cyc = -1;
      m_we = cpu_we;
      m_addr = cpu_addr;
      m_wd = cpu_wdata;
    end
    last_ack = e_ack;
    @(posedge clk_50MHz);
    c++;
    #1;
  endtask

  task automatic goto_slot(int s);
    for (int k = 0; k < 8; k++) begin
      if ((c % 8) == s) break;
      tick();
    end
  endtask

  task automatic wait_ack(output int ackc);
    logic seen;
    seen = 1'b0;
    ackc = -1;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (last_ack) begin
        seen = 1'b1;
        ackc = c - 1;
        break;
      end
    end
    chk("ack_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic do_cpu(logic we, logic [15:0] a, logic [15:0] d, output int ackc);
    we_cnt = 0;
    ack_slot = -1;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    wait_ack(ackc);
    cpu_req = 1'b0;
  endtask

  int  ack1, ack2, acc_before;
  logic req_on;

  initial begin
    checks = 0;
    errors = 0;
    m_reqs = 0;
    obs_acks = 0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i) ^ 16'h3C5A;
    clear = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = 16'h0;
    cpu_wdata = 16'h0;
    vga_fetch_en = 1'b0;
    vga_addr = 16'h0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk_50MHz);
    #1;
    chk("rst_counter", {29'b0, vga_counter}, 32'd0);
    chk("rst_ack", {31'b0, cpu_ack}, 32'd0);
    chk("rst_rdata", {16'b0, cpu_rdata}, 32'd0);
    chk("rst_vga", {16'b0, data_from_mem_vga}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    clear = 1'b0;
    model_reset();

    // write requested in slot 3
    goto_slot(3);
    do_cpu(1'b1, 16'h0010, 16'hBEEF, ack1);
    tick();
    chk("wr_count", 32'(we_cnt), 32'd1);
    chk("wr_slot", 32'(we_slot), 32'd4);
    chk("wr_addr", {16'b0, obs_addr[4]}, 32'h0010);
    chk("wr_ack_slot", 32'(ack_slot), 32'd5);
    chk("wr_mem", {16'b0, env_rd(16'h0010)}, 32'hBEEF);

    // read sampled in slot 2
    preload(16'h0020, 16'h1234);
    goto_slot(2);
    do_cpu(1'b0, 16'h0020, 16'h0000, ack1);
    chk("rd_addr", {16'b0, obs_addr[3]}, 32'h0020);
    chk("rd_ack_slot", 32'(ack_slot), 32'd5);
    chk("rd_data", {16'b0, cpu_rdata}, 32'h1234);

    // VGA fetch
    preload(16'h8000, 16'hA5A5);
    goto_slot(0);
    vga_fetch_en = 1'b1;
    vga_addr = 16'h8000;
    tick();
    chk("vga_addr_slot0", {16'b0, obs_addr[0]}, 32'h8000);
    vga_fetch_en = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    for (int k = 2; k <= 8; k++) chk("vga_hold", {16'b0, obs_vga[k % 8]}, 32'hA5A5);

    // collision: read pends onto the VGA slot
    preload(16'h0040, 16'h4040);
    preload(16'h0041, 16'h7777);
    vga_fetch_en = 1'b1;
    vga_addr = 16'h0041;
    goto_slot(7);
    do_cpu(1'b0, 16'h0040, 16'h0000, ack1);
    chk("col_vga_addr", {16'b0, obs_addr[0]}, 32'h0041);
    chk("col_cpu_addr", {16'b0, obs_addr[1]}, 32'h0040);
    chk("col_ack_slot", 32'(ack_slot), 32'd3);
    chk("col_rdata", {16'b0, cpu_rdata}, 32'h4040);
    tick();
    chk("col_vga_data", {16'b0, data_from_mem_vga}, 32'h7777);
    vga_fetch_en = 1'b0;

    // back-to-back: req held across ack
    goto_slot(1);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 16'h0005;
    cpu_wdata = 16'h1111;
    wait_ack(ack1);
    cpu_we = 1'b0;
    wait_ack(ack2);
    cpu_req = 1'b0;
    chk("b2b_gap", 32'(ack2 - ack1), 32'd4);
    chk("b2b_rdata", {16'b0, cpu_rdata}, 32'h1111);

    // reset while a read is in RDATA
    goto_slot(1);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0040;
    tick();
    tick();
    cpu_req = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    chk("mid_ack", {31'b0, cpu_ack}, 32'd0);
    chk("mid_rdata", {16'b0, cpu_rdata}, 32'd0);
    chk("mid_vga", {16'b0, data_from_mem_vga}, 32'd0);
    chk("mid_counter", {29'b0, vga_counter}, 32'd0);
    chk("mid_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("mid_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk_50MHz);
    #1;
    clear = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) tick();

    // randomized soak
    acc_before = m_reqs;
    obs_acks = 0;
    req_on = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      vga_fetch_en = 1'($urandom_range(0, 1));
      vga_addr = 16'($urandom_range(0, 63));
      if (!req_on && $urandom_range(0, 3) == 0) begin
        req_on = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 16'($urandom_range(0, 63));
        cpu_wdata = 16'($urandom_range(0, 65535));
      end
      cpu_req = req_on;
      tick();
      if (last_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = 16'($urandom_range(0, 63));
          cpu_wdata = 16'($urandom_range(0, 65535));
          cpu_req = 1'b1;
        end else begin
          req_on = 1'b0;
          cpu_req = 1'b0;
        end
      end
    end
    cpu_req = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (!m_busy) break;
      tick();
    end
    chk("soak_ack_count", 32'(obs_acks), 32'(m_reqs - acc_before));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
